// File: rtl/dds_word_ctrl.sv
// Multi-channel frequency/phase word controller for the DDS datapath.
// Each channel owns a debounced frequency key and phase key that step
// through a frequency table and a uniform phase table. A per-channel mode
// input switches the frequency word into a linear sweep. Upd marks the
// first cycle a channel's words hold a new value.
//
// Channel state machine:
//   state    | meaning
//   CH_STEP  | Fword follows F_TABLE[Fidx]; Key_f steps the index
//   CH_SWEEP | Fword ramps by SWEEP_INC every SWEEP_DIV clocks; Key_f ignored
module dds_word_ctrl #(
    parameter int                   NCH       = 2,
    parameter int                   FW        = 32,
    parameter int                   PW        = 12,      // must exceed IW
    parameter int                   NSTEP     = 8,       // power of 2, >= 2
    parameter int                   IW        = $clog2(NSTEP),
    parameter logic [NSTEP*FW-1:0]  F_TABLE   = {32'd429496730, 32'd85899346,
                                                 32'd8589935,   32'd1717987,
                                                 32'd858993,    32'd171798,
                                                 32'd85899,     32'd8589},
    parameter int                   DEB_CYC   = 1_000_000, // >= 2
    parameter int                   SWEEP_DIV = 5_000,     // >= 1
    parameter logic [FW-1:0]        SWEEP_INC = FW'(8589)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [NCH-1:0]    Key_f,
    input  logic [NCH-1:0]    Key_p,
    input  logic [NCH-1:0]    Mode,
    output logic [NCH*FW-1:0] Fword,
    output logic [NCH*PW-1:0] Pword,
    output logic [NCH*IW-1:0] Fidx,
    output logic [NCH-1:0]    Upd
);

    localparam int NKEY = 2 * NCH;

    // The stable counter reloads on the first sample of a new level, so it
    // needs DEB_CYC-1 further matching samples: reload DEB_CYC-2, accept at 0.
    localparam int DBW        = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
    localparam int DEB_RELOAD = (DEB_CYC >= 2) ? DEB_CYC - 2 : 0;

    localparam int DVW        = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
    localparam int DIV_RELOAD = SWEEP_DIV - 1;

    localparam logic [FW-1:0] F_FIRST = F_TABLE[FW-1:0];
    localparam logic [FW-1:0] F_LAST  = F_TABLE[NSTEP*FW-1 -: FW];

    typedef enum logic {
        CH_STEP  = 1'b0,
        CH_SWEEP = 1'b1
    } ch_state_e;

    logic [FW-1:0]   f_tab [NSTEP];
    logic [NKEY-1:0] key_raw;
    logic [NKEY-1:0] press;

    for (genvar t = 0; t < NSTEP; t++) begin : g_tab
        assign f_tab[t] = F_TABLE[t*FW +: FW];
    end

    // Keys [NCH-1:0] are frequency keys, [NKEY-1:NCH] are phase keys.
    assign key_raw = {Key_p, Key_f};

    for (genvar k = 0; k < NKEY; k++) begin : g_key
        logic [1:0]     sync_q;
        logic           last_q;
        logic           lvl_q;
        logic           armed_q;
        logic           press_q;
        logic [DBW-1:0] cnt_q;

        // Synchronise the key, time how long its level has been stable and
        // emit a one-cycle strobe when a low level is accepted. A key is only
        // armed once a stable released level has been seen, so a key held
        // through reset cannot fire on its own.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                sync_q  <= 2'b11;
                last_q  <= 1'b1;
                lvl_q   <= 1'b1;
                armed_q <= 1'b0;
                press_q <= 1'b0;
                cnt_q   <= DBW'(DEB_RELOAD);
            end else begin
                sync_q  <= {sync_q[0], key_raw[k]};
                press_q <= 1'b0;
                if (sync_q[1] != last_q) begin
                    last_q <= sync_q[1];
                    cnt_q  <= DBW'(DEB_RELOAD);
                end else if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end else begin
                    if (last_q) begin
                        armed_q <= 1'b1;
                    end
                    if (last_q != lvl_q) begin
                        lvl_q   <= last_q;
                        press_q <= !last_q && armed_q;
                    end
                end
            end
        end

        assign press[k] = press_q;
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [1:0]     mode_sync_q;
        ch_state_e      st_q;
        logic [IW-1:0]  fidx_q;
        logic [IW-1:0]  pidx_q;
        logic [FW-1:0]  fword_q;
        logic [PW-1:0]  pword_q;
        logic           upd_q;
        logic [DVW-1:0] div_q;

        logic           mode_s;
        logic           f_press;
        logic           p_press;
        logic [IW-1:0]  fidx_d;
        logic [IW-1:0]  pidx_d;
        logic [FW:0]    sweep_sum;
        logic [FW-1:0]  sweep_d;

        assign mode_s  = mode_sync_q[1];
        assign f_press = press[c];
        assign p_press = press[NCH + c];

        // Next index values and the next sweep word; the sum keeps a carry
        // bit so a large increment wraps to the table start instead of
        // overflowing into a small word.
        always_comb begin
            fidx_d    = fidx_q + 1'b1;
            pidx_d    = pidx_q + 1'b1;
            sweep_sum = {1'b0, fword_q} + {1'b0, SWEEP_INC};
            sweep_d   = F_FIRST;
            if (sweep_sum <= {1'b0, F_LAST}) begin
                sweep_d = sweep_sum[FW-1:0];
            end
        end

        // Channel controller: mode synchroniser, step/sweep state machine
        // and the registered word and strobe outputs. Mode edges take
        // priority over a frequency key strobe in the same cycle.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                mode_sync_q <= 2'b00;
                st_q        <= CH_STEP;
                fidx_q      <= '0;
                pidx_q      <= '0;
                fword_q     <= F_FIRST;
                pword_q     <= '0;
                upd_q       <= 1'b0;
                div_q       <= '0;
            end else begin
                mode_sync_q <= {mode_sync_q[0], Mode[c]};
                upd_q       <= 1'b0;

                if (p_press) begin
                    pidx_q  <= pidx_d;
                    pword_q <= {pidx_d, {(PW-IW){1'b0}}};
                    upd_q   <= 1'b1;
                end

                if (st_q == CH_STEP) begin
                    if (mode_s) begin
                        st_q    <= CH_SWEEP;
                        fword_q <= F_FIRST;
                        div_q   <= DVW'(DIV_RELOAD);
                        upd_q   <= 1'b1;
                    end else if (f_press) begin
                        fidx_q  <= fidx_d;
                        fword_q <= f_tab[fidx_d];
                        upd_q   <= 1'b1;
                    end
                end else begin
                    if (!mode_s) begin
                        st_q    <= CH_STEP;
                        fword_q <= f_tab[fidx_q];
                        upd_q   <= 1'b1;
                    end else if (div_q == '0) begin
                        div_q   <= DVW'(DIV_RELOAD);
                        fword_q <= sweep_d;
                        upd_q   <= 1'b1;
                    end else begin
                        div_q <= div_q - 1'b1;
                    end
                end
            end
        end

        assign Fword[c*FW +: FW] = fword_q;
        assign Pword[c*PW +: PW] = pword_q;
        assign Fidx[c*IW +: IW]  = fidx_q;
        assign Upd[c]            = upd_q;
    end

endmodule

// File: tb/tb_dds_word_ctrl.sv
// Bench for dds_word_ctrl: directed key/sweep scenarios plus random key
// traffic, checked against a table/counter model of the channel behaviour.
module tb_dds_word_ctrl;

    localparam int NCH   = 2;
    localparam int FW    = 32;
    localparam int PW    = 12;
    localparam int NSTEP = 8;
    localparam int IW    = 3;
    localparam int DEB   = 16;
    localparam int SDIV  = 4;
    localparam longint unsigned INC  = 8589;
    localparam longint unsigned WINC = 100_000_000;
    localparam longint unsigned PSTEP = (1 << PW) / NSTEP;

    longint unsigned ftab [NSTEP] = '{8589, 85899, 171798, 858993,
                                      1717987, 8589935, 85899346, 429496730};

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic [NCH-1:0]    key_f, key_p, mode;
    logic [NCH*FW-1:0] fword;
    logic [NCH*PW-1:0] pword;
    logic [NCH*IW-1:0] fidx;
    logic [NCH-1:0]    upd;

    logic              w_key_f, w_key_p, w_mode;
    logic [FW-1:0]     w_fword;
    logic [PW-1:0]     w_pword;
    logic [IW-1:0]     w_fidx;
    logic              w_upd;

    dds_word_ctrl #(.NCH(NCH), .DEB_CYC(DEB), .SWEEP_DIV(SDIV)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .Key_f(key_f), .Key_p(key_p), .Mode(mode),
        .Fword(fword), .Pword(pword), .Fidx(fidx), .Upd(upd)
    );

    // Large increment so the sweep reaches the top of the table quickly.
    dds_word_ctrl #(.NCH(1), .DEB_CYC(DEB), .SWEEP_DIV(SDIV),
                    .SWEEP_INC(32'd100_000_000)) u_wrap (
        .Clk(Clk), .Reset_n(Reset_n), .Key_f(w_key_f), .Key_p(w_key_p), .Mode(w_mode),
        .Fword(w_fword), .Pword(w_pword), .Fidx(w_fidx), .Upd(w_upd)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int upd_cnt [NCH];
    bit rec_en = 1'b0;
    bit w_rec = 1'b0;
    longint unsigned rec_val [$];
    int rec_cyc [$];
    longint unsigned w_val [$];

    // model state
    int m_fidx [NCH];
    int m_pidx [NCH];
    bit m_sweep [NCH];

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (upd[c]) upd_cnt[c] = upd_cnt[c] + 1;
        end
        if (rec_en && upd[0]) begin
            rec_val.push_back(longint'(fword[FW-1:0]));
            rec_cyc.push_back(cyc);
        end
        if (w_rec && w_upd) w_val.push_back(longint'(w_fword));
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [FW-1:0] obs_f(input int c);
        return FW'(fword >> (c * FW));
    endfunction

    function automatic logic [PW-1:0] obs_p(input int c);
        return PW'(pword >> (c * PW));
    endfunction

    function automatic logic [IW-1:0] obs_i(input int c);
        return IW'(fidx >> (c * IW));
    endfunction

    function automatic longint unsigned sweep_next(input longint unsigned v, input longint unsigned inc);
        return (v + inc > ftab[NSTEP-1]) ? ftab[0] : v + inc;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_fidx[c] = 0;
            m_pidx[c] = 0;
            m_sweep[c] = 1'b0;
        end
    endtask

    // Drive one key low for len cycles, release, and let it settle.
    // Returns how many Upd pulses the model expects from it.
    task automatic press(input bit is_p, input int ch, input int len, output int exp_upd);
        if (is_p) key_p[ch] = 1'b0; else key_f[ch] = 1'b0;
        cycles(len);
        if (is_p) key_p[ch] = 1'b1; else key_f[ch] = 1'b1;
        cycles(DEB + 10);
        exp_upd = 0;
        if (len >= DEB) begin
            if (is_p) begin
                m_pidx[ch] = (m_pidx[ch] + 1) % NSTEP;
                exp_upd = 1;
            end else if (!m_sweep[ch]) begin
                m_fidx[ch] = (m_fidx[ch] + 1) % NSTEP;
                exp_upd = 1;
            end
        end
    endtask

    task automatic check_ch(input string tag, input int c, input int base, input int exp_upd);
        check_eq($sformatf("%s_fword%0d", tag, c), obs_f(c), ftab[m_fidx[c]]);
        check_eq($sformatf("%s_pword%0d", tag, c), obs_p(c), m_pidx[c] * PSTEP);
        check_eq($sformatf("%s_fidx%0d", tag, c), obs_i(c), m_fidx[c]);
        check_eq($sformatf("%s_upd%0d", tag, c), upd_cnt[c] - base, exp_upd);
    endtask

    initial begin
        int b0, b1, eu, ch, len;
        bit is_p, seen;
        longint unsigned v;

        Reset_n = 1'b1;
        key_f = '1; key_p = '1; mode = '0;
        w_key_f = 1'b1; w_key_p = 1'b1; w_mode = 1'b0;
        for (int c = 0; c < NCH; c++) upd_cnt[c] = 0;
        model_reset();
        #2 Reset_n = 1'b0;
        cycles(3);
        for (int c = 0; c < NCH; c++) begin
            check_eq($sformatf("rst_fword%0d", c), obs_f(c), ftab[0]);
            check_eq($sformatf("rst_pword%0d", c), obs_p(c), 0);
            check_eq($sformatf("rst_fidx%0d", c), obs_i(c), 0);
        end
        check_eq("rst_upd", upd, 0);
        Reset_n = 1'b1;
        cycles(DEB + 8);

        // frequency key on ch0: first press, then wrap around the table
        b0 = upd_cnt[0]; b1 = upd_cnt[1];
        press(1'b0, 0, 40, eu);
        check_ch("f_first", 0, b0, eu);
        check_ch("f_first", 1, b1, 0);
        for (int i = 0; i < NSTEP - 1; i++) begin
            b0 = upd_cnt[0];
            press(1'b0, 0, 30, eu);
            check_eq("f_step_upd", upd_cnt[0] - b0, eu);
        end
        check_ch("f_wrap", 0, upd_cnt[0], 0);

        // phase key on ch1: a short glitch, then presses around the circle
        b1 = upd_cnt[1];
        press(1'b1, 1, 10, eu);
        check_ch("p_glitch", 1, b1, 0);
        for (int i = 0; i < 3; i++) press(1'b1, 1, 30, eu);
        check_ch("p_three", 1, b1, 3);
        check_eq("p_three_val", obs_p(1), 1536);
        for (int i = 0; i < NSTEP - 3; i++) press(1'b1, 1, 30, eu);
        check_ch("p_wrap", 1, b1, NSTEP);

        // random key traffic, step mode
        for (int i = 0; i < 24; i++) begin
            ch   = $urandom_range(0, NCH - 1);
            is_p = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, DEB - 4);
            else len = $urandom_range(DEB + 4, 40);
            b0 = upd_cnt[ch]; b1 = upd_cnt[1 - ch];
            press(is_p, ch, len, eu);
            check_ch($sformatf("rnd%0d", i), ch, b0, eu);
            check_ch($sformatf("rnd%0d_other", i), 1 - ch, b1, 0);
        end

        // sweep on ch0 from Fidx 3 (and the wrap instance alongside)
        for (int i = 0; i < NSTEP && m_fidx[0] != 3; i++) press(1'b0, 0, 30, eu);
        check_eq("sw_pre_fword", obs_f(0), 858993);
        rec_val.delete(); rec_cyc.delete(); w_val.delete();
        rec_en = 1'b1; w_rec = 1'b1;
        mode[0] = 1'b1; w_mode = 1'b1;
        m_sweep[0] = 1'b1;
        cycles(40);
        press(1'b0, 0, 30, eu);
        rec_en = 1'b0; w_rec = 1'b0;
        check_eq("sw_fidx_held", obs_i(0), 3);
        check_eq("sw_upd_count_ok", rec_val.size() >= 20, 1);
        v = ftab[0];
        for (int i = 0; i < rec_val.size() && i < 24; i++) begin
            check_eq($sformatf("sw_val%0d", i), rec_val[i], v);
            if (i > 0) check_eq($sformatf("sw_gap%0d", i), rec_cyc[i] - rec_cyc[i-1], SDIV);
            v = sweep_next(v, INC);
        end
        check_eq("wrap_count_ok", w_val.size() >= 12, 1);
        v = ftab[0];
        for (int i = 0; i < w_val.size() && i < 12; i++) begin
            check_eq($sformatf("wrap_val%0d", i), w_val[i], v);
            v = sweep_next(v, WINC);
        end
        w_mode = 1'b0;

        // leave sweep right after a sweep update so only the exit pulses
        seen = 1'b0;
        for (int i = 0; i < 4 * SDIV && !seen; i++) begin
            @(negedge Clk);
            if (upd[0]) seen = 1'b1;
        end
        check_eq("sw_tick_seen", seen, 1);
        @(posedge Clk); #1;
        b0 = upd_cnt[0];
        mode[0] = 1'b0;
        m_sweep[0] = 1'b0;
        cycles(10);
        check_ch("sw_exit", 0, b0, 1);

        // both keys of ch0 pressed together
        b0 = upd_cnt[0];
        key_f[0] = 1'b0; key_p[0] = 1'b0;
        cycles(30);
        key_f[0] = 1'b1; key_p[0] = 1'b1;
        cycles(DEB + 10);
        m_fidx[0] = (m_fidx[0] + 1) % NSTEP;
        m_pidx[0] = (m_pidx[0] + 1) % NSTEP;
        check_ch("both", 0, b0, 1);

        // reset mid-sweep with Key_f[0] held low
        mode[0] = 1'b1;
        cycles(20);
        key_f[0] = 1'b0;
        cycles(5);
        Reset_n = 1'b0;
        #2;
        model_reset();
        check_eq("mid_rst_fword0", obs_f(0), ftab[0]);
        check_eq("mid_rst_pword0", obs_p(0), 0);
        check_eq("mid_rst_fidx0", obs_i(0), 0);
        check_eq("mid_rst_upd", upd, 0);
        check_eq("mid_rst_fword1", obs_f(1), ftab[0]);
        mode[0] = 1'b0;
        cycles(3);
        Reset_n = 1'b1;
        b0 = upd_cnt[0];
        cycles(60);
        check_ch("held_after_rst", 0, b0, 0);
        key_f[0] = 1'b1;
        cycles(DEB + 10);
        check_ch("released_after_rst", 0, b0, 0);
        press(1'b0, 0, 30, eu);
        check_ch("repress_after_rst", 0, b0, eu);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
